// File: rtl/datapath_regs.sv
// Register file and shared-bus datapath sitting under the microcoded control unit.
// Holds PC, AR, DR, IR, AC, R, R1-R4 and returns opcode and AC-zero flag to control.
module datapath_regs #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        read_en,
  input  logic [15:0]       write_en,
  input  logic [15:0]       inc_en,
  input  logic [15:0]       clr_en,
  input  logic              halt,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] dm_rdata,
  input  logic [DATA_W-1:0] im_rdata,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  output logic              dm_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [DATA_W-1:0] bus,
  output logic [5:0]        instruction,
  output logic [15:0]       z,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] ar,
  output logic [DATA_W-1:0] ac
);

  logic [ADDR_W-1:0] pc_q, pc_d, ar_q, ar_d;
  logic [DATA_W-1:0] dr_q, dr_d, ir_q, ir_d, ac_q, ac_d, r_q, r_d;
  logic [DATA_W-1:0] r1_q, r1_d, r2_q, r2_d, r3_q, r3_d, r4_q, r4_d;
  logic [DATA_W-1:0] ac_ld;
  logic              unused_strobes;

  // Per-register update: clear beats load, load beats increment.
  function automatic logic [DATA_W-1:0] nxt_data(input logic [DATA_W-1:0] q,
                                                 input logic [DATA_W-1:0] ld,
                                                 input logic clr, input logic wr,
                                                 input logic inc);
    logic [DATA_W-1:0] n;
    n = q;
    if (clr)      n = '0;
    else if (wr)  n = ld;
    else if (inc) n = q + DATA_W'(1);
    return n;
  endfunction

  function automatic logic [ADDR_W-1:0] nxt_addr(input logic [ADDR_W-1:0] q,
                                                 input logic [ADDR_W-1:0] ld,
                                                 input logic clr, input logic wr,
                                                 input logic inc);
    logic [ADDR_W-1:0] n;
    n = q;
    if (clr)      n = '0;
    else if (wr)  n = ld;
    else if (inc) n = q + ADDR_W'(1);
    return n;
  endfunction

  always_comb begin
    bus = '0;
    case (read_en)
      4'd1:  bus = DATA_W'(pc_q);
      4'd2:  bus = DATA_W'(ar_q);
      4'd3:  bus = dr_q;
      4'd4:  bus = ir_q;
      4'd5:  bus = ac_q;
      4'd6:  bus = r_q;
      4'd7:  bus = r1_q;
      4'd8:  bus = r2_q;
      4'd9:  bus = r3_q;
      4'd10: bus = r4_q;
      4'd12: bus = dm_rdata;
      4'd13: bus = im_rdata;
      4'd14: bus = ac_q;
      default: bus = '0;
    endcase
  end

  // write_en[12] routes the ALU result into AC and overrides a bus load.
  assign ac_ld = write_en[12] ? alu_result : bus;

  always_comb begin
    pc_d = pc_q;
    ar_d = ar_q;
    dr_d = dr_q;
    ir_d = ir_q;
    ac_d = ac_q;
    r_d  = r_q;
    r1_d = r1_q;
    r2_d = r2_q;
    r3_d = r3_q;
    r4_d = r4_q;
    if (!halt) begin
      pc_d = nxt_addr(pc_q, ADDR_W'(bus), clr_en[1], write_en[1], inc_en[1]);
      ar_d = nxt_addr(ar_q, ADDR_W'(bus), clr_en[2], write_en[2], inc_en[2]);
      ir_d = nxt_data(ir_q, bus, clr_en[3], write_en[3], inc_en[3]);
      ac_d = nxt_data(ac_q, ac_ld, clr_en[4], write_en[4] | write_en[12], inc_en[4]);
      r_d  = nxt_data(r_q,  bus, clr_en[5],  write_en[5],  inc_en[5]);
      r4_d = nxt_data(r4_q, bus, clr_en[7],  write_en[7],  inc_en[7]);
      r3_d = nxt_data(r3_q, bus, clr_en[8],  write_en[8],  inc_en[8]);
      r2_d = nxt_data(r2_q, bus, clr_en[9],  write_en[9],  inc_en[9]);
      r1_d = nxt_data(r1_q, bus, clr_en[10], write_en[10], inc_en[10]);
      if (read_en == 4'd12) dr_d = dm_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= '0;
      ar_q <= '0;
      dr_q <= '0;
      ir_q <= '0;
      ac_q <= '0;
      r_q  <= '0;
      r1_q <= '0;
      r2_q <= '0;
      r3_q <= '0;
      r4_q <= '0;
    end else begin
      pc_q <= pc_d;
      ar_q <= ar_d;
      dr_q <= dr_d;
      ir_q <= ir_d;
      ac_q <= ac_d;
      r_q  <= r_d;
      r1_q <= r1_d;
      r2_q <= r2_d;
      r3_q <= r3_d;
      r4_q <= r4_d;
    end
  end

  assign alu_a       = ac_q;
  assign alu_b       = r_q;
  assign dm_addr     = ar_q;
  assign dm_wdata    = bus;
  assign dm_we       = write_en[11] & ~halt;
  assign im_addr     = pc_q;
  assign instruction = ir_q[5:0];
  assign z           = {15'd0, (ac_q == '0)};
  assign pc          = pc_q;
  assign ar          = ar_q;
  assign ac          = ac_q;

  assign unused_strobes = ^{write_en[0], write_en[6], write_en[15:13],
                            inc_en[0], inc_en[6], inc_en[15:11],
                            clr_en[0], clr_en[6], clr_en[15:11]};

endmodule

// File: tb/tb_datapath_regs.sv
// Bench for datapath_regs: directed register-transfer sequences with a queue of
// expected post-edge values, drained after each clock edge.
module tb_datapath_regs;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  read_en;
  logic [15:0] write_en, inc_en, clr_en;
  logic        halt;
  logic [15:0] alu_result, dm_rdata, im_rdata;
  logic [15:0] alu_a, alu_b, dm_addr, dm_wdata, im_addr, bus, z, pc, ar, ac;
  logic        dm_we;
  logic [5:0]  instruction;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    string       tag;
    int          sel;
    logic [15:0] exp;
  } exp_t;
  exp_t sb[$];

  localparam int S_PC = 0, S_AR = 1, S_AC = 2, S_BUS = 3, S_Z = 4, S_INS = 5,
                 S_WE = 6, S_DMA = 7, S_DMW = 8, S_IMA = 9, S_ALUA = 10, S_ALUB = 11;

  datapath_regs #(.DATA_W(16), .ADDR_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .read_en(read_en), .write_en(write_en),
    .inc_en(inc_en), .clr_en(clr_en), .halt(halt), .alu_result(alu_result),
    .dm_rdata(dm_rdata), .im_rdata(im_rdata), .alu_a(alu_a), .alu_b(alu_b),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_we(dm_we), .im_addr(im_addr),
    .bus(bus), .instruction(instruction), .z(z), .pc(pc), .ar(ar), .ac(ac)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] obs(input int sel);
    case (sel)
      S_PC:   return pc;
      S_AR:   return ar;
      S_AC:   return ac;
      S_BUS:  return bus;
      S_Z:    return z;
      S_INS:  return {10'd0, instruction};
      S_WE:   return {15'd0, dm_we};
      S_DMA:  return dm_addr;
      S_DMW:  return dm_wdata;
      S_IMA:  return im_addr;
      S_ALUA: return alu_a;
      S_ALUB: return alu_b;
      default: return 16'hDEAD;
    endcase
  endfunction

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic expect_after(input string tag, input int sel, input logic [15:0] exp);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, obs(e.sel), e.exp);
    end
  endtask

  task automatic idle();
    read_en  = 4'd0;
    write_en = 16'd0;
    inc_en   = 16'd0;
    clr_en   = 16'd0;
    halt     = 1'b0;
  endtask

  // Load a value into registers via the im_rdata bus source.
  task automatic load_im(input logic [15:0] v, input logic [15:0] we);
    idle();
    im_rdata = v;
    read_en  = 4'd13;
    write_en = we;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    idle();
    alu_result = 16'd0;
    dm_rdata   = 16'd0;
    im_rdata   = 16'd0;

    // Reset held with random strobes
    for (int i = 0; i < 3; i++) begin
      read_en    = 4'($urandom);
      write_en   = 16'($urandom);
      inc_en     = 16'($urandom);
      clr_en     = 16'($urandom);
      halt       = 1'($urandom);
      im_rdata   = 16'($urandom);
      alu_result = 16'($urandom);
      @(posedge clk);
      #1;
      check("rst_pc", pc, 16'd0);
      check("rst_ar", ar, 16'd0);
      check("rst_ac", ac, 16'd0);
      check("rst_z", z, 16'd1);
      check("rst_instr", {10'd0, instruction}, 16'd0);
    end
    idle();
    im_rdata = 16'd0;
    alu_result = 16'd0;
    #1;
    check("rst_bus", bus, 16'd0);
    check("rst_we", {15'd0, dm_we}, 16'd0);
    rst_n = 1'b1;
    expect_after("idle_pc", S_PC, 16'd0);
    expect_after("idle_ar", S_AR, 16'd0);
    expect_after("idle_ac", S_AC, 16'd0);
    tick();

    // Fetch
    load_im(16'h0013, 16'h0008);
    #1;
    check("fetch_bus", bus, 16'h0013);
    expect_after("fetch_instr", S_INS, 16'd19);
    expect_after("fetch_pc", S_PC, 16'd0);
    tick();
    idle();
    read_en = 4'd4;
    inc_en  = 16'h0002;
    expect_after("pc_inc", S_PC, 16'd1);
    expect_after("im_addr", S_IMA, 16'd1);
    expect_after("ir_on_bus", S_BUS, 16'h0013);
    tick();

    // Move and ALU writeback
    load_im(16'h0005, 16'h0010);
    expect_after("ac_load", S_AC, 16'h0005);
    expect_after("alu_a", S_ALUA, 16'h0005);
    tick();
    idle();
    read_en  = 4'd5;
    write_en = 16'h0420;
    expect_after("r_load", S_ALUB, 16'h0005);
    tick();
    idle();
    read_en = 4'd7;
    #1;
    check("r1_bus", bus, 16'h0005);
    idle();
    alu_result = 16'h000A;
    write_en   = 16'h1010;
    expect_after("alu_to_ac", S_AC, 16'h000A);
    expect_after("z_nonzero", S_Z, 16'd0);
    tick();

    // Store, then halt suppression
    load_im(16'h0020, 16'h0004);
    expect_after("ar_load", S_AR, 16'h0020);
    tick();
    load_im(16'h1234, 16'h0010);
    expect_after("ac_1234", S_AC, 16'h1234);
    tick();
    idle();
    read_en  = 4'd5;
    write_en = 16'h0800;
    #1;
    check("st_we", {15'd0, dm_we}, 16'd1);
    check("st_addr", dm_addr, 16'h0020);
    check("st_wdata", dm_wdata, 16'h1234);
    halt     = 1'b1;
    write_en = 16'h0812;
    inc_en   = 16'h0012;
    clr_en   = 16'h0004;
    #1;
    check("halt_we", {15'd0, dm_we}, 16'd0);
    check("halt_bus", bus, 16'h1234);
    expect_after("halt_pc", S_PC, 16'd1);
    expect_after("halt_ac", S_AC, 16'h1234);
    expect_after("halt_ar", S_AR, 16'h0020);
    tick();

    // Wrap and priority
    load_im(16'hFFFF, 16'h0002);
    expect_after("pc_ffff", S_PC, 16'hFFFF);
    tick();
    idle();
    inc_en = 16'h0002;
    expect_after("pc_wrap", S_PC, 16'h0000);
    tick();
    load_im(16'h0040, 16'h0002);
    inc_en = 16'h0002;
    expect_after("pc_wr_over_inc", S_PC, 16'h0040);
    tick();
    load_im(16'h0007, 16'h0010);
    clr_en = 16'h0010;
    inc_en = 16'h0010;
    expect_after("ac_clr_prio", S_AC, 16'h0000);
    expect_after("ac_clr_z", S_Z, 16'd1);
    tick();
    load_im(16'hFFFF, 16'h0010);
    expect_after("ac_ffff_z", S_Z, 16'd0);
    tick();
    idle();
    inc_en = 16'h0010;
    expect_after("ac_wrap", S_AC, 16'h0000);
    expect_after("ac_wrap_z", S_Z, 16'd1);
    tick();

    // DR capture and multi-register load
    idle();
    read_en  = 4'd12;
    dm_rdata = 16'hBEEF;
    tick();
    idle();
    dm_rdata = 16'h0000;
    read_en  = 4'd3;
    #1;
    check("dr_hold", bus, 16'hBEEF);
    write_en = 16'h0094;
    expect_after("multi_ar", S_AR, 16'hBEEF);
    expect_after("multi_ac", S_AC, 16'hBEEF);
    tick();
    idle();
    read_en = 4'd10;
    #1;
    check("multi_r4", bus, 16'hBEEF);
    read_en = 4'd11;
    #1;
    check("code11_zero", bus, 16'd0);

    // Asynchronous reset mid-cycle
    #2;
    rst_n = 1'b0;
    #1;
    check("async_pc", pc, 16'd0);
    check("async_ac", ac, 16'd0);
    check("async_ar", ar, 16'd0);
    idle();
    inc_en = 16'h0002;
    #1;
    rst_n = 1'b1;
    expect_after("post_rst_pc", S_PC, 16'd1);
    expect_after("post_rst_z", S_Z, 16'd1);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
